// File: rtl/gnr_step_ctrl.sv
// gnr_step_ctrl: sequences reset/step pulses to a node array and streams per-step state samples.
// Optional macro GNR_FIXED_POINT_DET_EN ends a run early once the s1 vector stops changing.
module gnr_step_ctrl #(
   parameter int NODES  = 8,
   parameter int STEP_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [STEP_W-1:0] cfg_steps,
   input  logic [NODES-1:0]  init_vec,
   output logic              reset_nos,
   output logic [NODES-1:0]  init_state,
   output logic              start_s0,
   output logic              start_s1,
   input  logic [NODES-1:0]  s0_vec,
   input  logic [NODES-1:0]  s1_vec,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [NODES-1:0]  out_s0,
   output logic [NODES-1:0]  out_s1,
   output logic [STEP_W-1:0] out_step,
   output logic              busy,
   output logic              done,
   output logic              fixed_point
);
   typedef enum logic [2:0] {IDLE, INIT, STEP, SAMPLE, EMIT, DONE} state_t;
   state_t state_q, state_d;
   logic [STEP_W-1:0] steps_q, steps_d, cnt_q, cnt_d, out_step_q, out_step_d;
   logic [NODES-1:0] init_q, init_d, s0_q, s0_d, s1_q, s1_d;
`ifdef GNR_FIXED_POINT_DET_EN
   logic [NODES-1:0] prev_q, prev_d;
   logic fp_q, fp_d;
`endif
   always_comb begin
      state_d    = state_q;
      steps_d    = steps_q;
      cnt_d      = cnt_q;
      out_step_d = out_step_q;
      init_d     = init_q;
      s0_d       = s0_q;
      s1_d       = s1_q;
`ifdef GNR_FIXED_POINT_DET_EN
      prev_d     = prev_q;
      fp_d       = fp_q;
`endif
      case (state_q)
         IDLE: if (start) begin
            steps_d = cfg_steps;
            init_d  = init_vec;
            cnt_d   = '0;
            state_d = INIT;
`ifdef GNR_FIXED_POINT_DET_EN
            fp_d    = 1'b0;
`endif
         end
         INIT: state_d = SAMPLE;
         STEP: begin
            cnt_d   = cnt_q + 1'b1;
            state_d = SAMPLE;
         end
         SAMPLE: begin
            s0_d       = s0_vec;
            s1_d       = s1_vec;
            out_step_d = cnt_q;
            state_d    = EMIT;
         end
         EMIT: if (out_ready) begin
            // comparing before any increment lets an all-ones step count finish without wrapping
            state_d = (cnt_q == steps_q) ? DONE : STEP;
`ifdef GNR_FIXED_POINT_DET_EN
            prev_d = s1_q;
            if (out_step_q != '0 && s1_q == prev_q) begin
               state_d = DONE;
               fp_d    = 1'b1;
            end
`endif
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         steps_q    <= '0;
         cnt_q      <= '0;
         out_step_q <= '0;
         init_q     <= '0;
         s0_q       <= '0;
         s1_q       <= '0;
`ifdef GNR_FIXED_POINT_DET_EN
         prev_q     <= '0;
         fp_q       <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         steps_q    <= steps_d;
         cnt_q      <= cnt_d;
         out_step_q <= out_step_d;
         init_q     <= init_d;
         s0_q       <= s0_d;
         s1_q       <= s1_d;
`ifdef GNR_FIXED_POINT_DET_EN
         prev_q     <= prev_d;
         fp_q       <= fp_d;
`endif
      end
   end
   assign reset_nos  = state_q == INIT;
   assign start_s0   = state_q == STEP;
   assign start_s1   = state_q == STEP;
   assign out_valid  = state_q == EMIT;
   assign busy       = state_q != IDLE;
   assign done       = state_q == DONE;
   assign init_state = init_q;
   assign out_s0     = s0_q;
   assign out_s1     = s1_q;
   assign out_step   = out_step_q;
`ifdef GNR_FIXED_POINT_DET_EN
   assign fixed_point = fp_q;
`else
   assign fixed_point = 1'b0;
`endif
endmodule

// File: doc/gnr_step_ctrl.md
Name: gnr_step_ctrl

Overview:
- Sequencer that drives a bank of boolean-network node cells of the stat5 node type: it issues reset_nos with per-node init_state, then pulses start_s0/start_s1 once per step.
- After each step it samples the nodes' s0/s1 state vectors and streams them out over a valid/ready handshake.
- Sits between the host-facing configuration/output logic and the node array. It is the initiator for the node cells' step protocol.

Parameters:
- NODES, 8, number of node cells controlled; width of state and init vectors.
- STEP_W, 16, width of step counter and cfg_steps.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  single-cycle run request, honoured only in IDLE
- cfg_steps  input  STEP_W  number of network steps to run; captured on accepted start
- init_vec  input  NODES  initial node states; captured on accepted start
- reset_nos  output  1  broadcast node re-initialise pulse
- init_state  output  NODES  per-node init value (bit i to node i); holds captured init_vec
- start_s0  output  1  broadcast s0 step pulse
- start_s1  output  1  broadcast s1 step pulse
- s0_vec  input  NODES  node s0 outputs, bit i from node i
- s1_vec  input  NODES  node s1 outputs
- out_valid  output  1  sample available
- out_ready  input  1  downstream accepts sample
- out_s0  output  NODES  sampled s0 vector
- out_s1  output  NODES  sampled s1 vector
- out_step  output  STEP_W  step index of sample (0 = initial state)
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse at run end
- fixed_point  output  1  see Optional Feature

Behaviour:
- Reset (rst_n=0 at clk edge): FSM to IDLE. All outputs 0, including init_state, out_s0, out_s1, out_step, done and fixed_point. Reset mid-run aborts immediately; no done pulse is produced.
- reset_nos, start_s0, start_s1, out_valid, busy and done are decoded only from the state register. No combinational path runs from any input to any output.
- FSM states:
  - IDLE: on start=1, capture cfg_steps and init_vec, clear step_cnt, go to INIT. start in any other state is ignored.
  - INIT: reset_nos=1 for exactly 1 cycle, then go to SAMPLE.
  - STEP: start_s0=start_s1=1 for exactly 1 cycle, increment step_cnt, then go to SAMPLE.
  - SAMPLE: 1 cycle, waiting for the node registers. At its end, capture s0_vec→out_s0, s1_vec→out_s1, step_cnt→out_step. Go to EMIT.
  - EMIT: out_valid=1 and held stable while out_ready=0.
    - On out_valid&out_ready: if step_cnt==cfg_steps go to DONE, else go to STEP.
  - DONE: done=1 for 1 cycle, then go to IDLE.
- Backpressure stalls the network: no start_s* pulse is issued while a sample is unaccepted.
- Latency:
  - start accepted at edge E; reset_nos high in cycle E+1; first out_valid in cycle E+3.
  - Per subsequent step, minimum 3 cycles (STEP, SAMPLE, EMIT).
- Sample count per run = cfg_steps+1.
  - cfg_steps=0: only the initial state is emitted, then DONE.
  - cfg_steps=all-ones: full count, no wrap. step_cnt is STEP_W wide and compared before increment.
- Node s0 updates on alternate start_s0 pulses after reset_nos (the first pulse updates). The controller does not compensate; out_s0 reflects node output as-is.
- init_state holds the captured init_vec until the next accepted start.

Optional Feature:
- Macro: GNR_FIXED_POINT_DET_EN.
- With the macro defined:
  - The controller keeps the previously emitted out_s1.
  - In EMIT, on handshake with out_step≥1 and the new out_s1 equal to the previous one, it goes to DONE early and sets fixed_point=1.
  - fixed_point holds until the next accepted start or reset.
- Without the macro: no comparison logic is built, fixed_point is tied 0, and every run executes the full cfg_steps.

Test Plan:
- Reset: rst_n=0 for 2 cycles during a run with out_valid=1 → next cycle all outputs 0, busy=0, no done; a subsequent start works normally.
- Basic run: NODES=8, init_vec=8'hA5, cfg_steps=3, out_ready=1 → reset_nos single pulse at E+1 with init_state=8'hA5. Exactly 4 samples with out_step 0,1,2,3; sample 0 has out_s1=8'hA5. Exactly 3 start_s0/start_s1 pulses; done 1 cycle after the last handshake.
- Backpressure: out_ready=0 for 10 cycles on sample 1 → out_valid, out_s0, out_s1 and out_step stable. No start_s* pulses during the stall; run resumes after out_ready=1.
- Zero steps, busy start: cfg_steps=0 → one sample, step 0, no start_s* pulses. A start asserted while busy=1 is ignored (no recapture, no extra reset_nos).
- Fixed point (macro defined): node model with s1 constant 8'h3C, cfg_steps=10 → samples for steps 0 and 1 only, then done with fixed_point=1. Without the macro: 11 samples and fixed_point=0.
